// File: rtl/sr_pkg.sv
// Shared policy constants and request decoding for the set/reset flag storage.
package sr_pkg;

   localparam int CONF_HOLD = 0;
   localparam int CONF_RST  = 1;
   localparam int CONF_SET  = 2;

   // {s, r} request as seen by one lane while enabled
   typedef enum logic [1:0] {
      REQ_HOLD = 2'b00,
      REQ_RST  = 2'b01,
      REQ_SET  = 2'b10,
      REQ_BOTH = 2'b11
   } sr_req_e;

   // Next q for a simultaneous set/reset; unknown policies fall back to hold
   function automatic logic resolve_conflict(input int policy, input logic q_cur);
      logic q_res;
      case (policy)
         CONF_RST: q_res = 1'b0;
         CONF_SET: q_res = 1'b1;
         default:  q_res = q_cur;
      endcase
      return q_res;
   endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR lane: state register plus enable-gated next-state logic.
module sr_cell
   import sr_pkg::*;
#(
   parameter int   CONFLICT_P = CONF_HOLD,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic s,
   input  logic r,
   input  logic en,
   output logic q,
   output logic conflict
);

   logic    q_nxt;
   sr_req_e req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= RST_VAL;
      else     q <= q_nxt;
   end

   // s/r are only decoded under en, so unknowns on them cannot reach q while disabled
   always_comb begin
      q_nxt    = q;
      conflict = 1'b0;
      req      = REQ_HOLD;
      if (en) begin
         req = sr_req_e'({s, r});
         case (req)
            REQ_SET:  q_nxt = 1'b1;
            REQ_RST:  q_nxt = 1'b0;
            REQ_BOTH: begin
               q_nxt    = resolve_conflict(CONFLICT_P, q);
               conflict = 1'b1;
            end
            default:  q_nxt = q;
         endcase
      end
   end

endmodule

// File: rtl/sr_latch.sv
// WIDTH-lane clocked SR flag register with complementary outputs and sticky conflict flag.
module sr_latch
   import sr_pkg::*;
#(
   parameter int unsigned      WIDTH      = 1,
   parameter int               CONFLICT_P = CONF_HOLD,
   parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             err
);

   logic [WIDTH-1:0] conflict;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_lane
      sr_cell #(
         .CONFLICT_P (CONFLICT_P),
         .RST_VAL    (RST_VAL[i])
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .s        (s[i]),
         .r        (r[i]),
         .en       (en),
         .q        (q[i]),
         .conflict (conflict[i])
      );
   end

   // Sticky until reset; conflict is already gated by en inside each lane
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            err <= 1'b0;
      else if (|conflict) err <= 1'b1;
   end

   // Pure inverter on the q flops, so q==qb can never be observed
   assign qb = ~q;

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboard bench for sr_latch across widths and conflict policies.
module tb_sr_latch;
   import sr_pkg::*;

   typedef struct packed {
      logic [3:0][3:0] q;
      logic [3:0]      e;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [3:0] s   = 4'h0;
   logic [3:0] r   = 4'h0;

   logic       q0, qb0, err0, q1, qb1, err1, q2, qb2, err2, err4;
   logic [3:0] q4, qb4;

   int vectors     = 0;
   int miscompares = 0;

   logic [3:0] mq [4];
   logic       me [4];
   int         pol [4] = '{CONF_HOLD, CONF_RST, CONF_SET, CONF_HOLD};
   exp_t       sb [$];

   always #5 clk = ~clk;

   sr_latch #(.WIDTH(1), .CONFLICT_P(CONF_HOLD)) d0 (
      .clk(clk), .rst(rst), .s(s[0]), .r(r[0]), .en(en), .q(q0), .qb(qb0), .err(err0));
   sr_latch #(.WIDTH(1), .CONFLICT_P(CONF_RST)) d1 (
      .clk(clk), .rst(rst), .s(s[0]), .r(r[0]), .en(en), .q(q1), .qb(qb1), .err(err1));
   sr_latch #(.WIDTH(1), .CONFLICT_P(CONF_SET)) d2 (
      .clk(clk), .rst(rst), .s(s[0]), .r(r[0]), .en(en), .q(q2), .qb(qb2), .err(err2));
   sr_latch #(.WIDTH(4), .CONFLICT_P(CONF_HOLD)) d4 (
      .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .q(q4), .qb(qb4), .err(err4));

   function automatic logic [3:0] model_next(input logic [3:0] qc, input int p,
                                             input logic e, input logic [3:0] sv,
                                             input logic [3:0] rv);
      logic [3:0] n;
      n = qc;
      if (e) begin
         for (int i = 0; i < 4; i++) begin
            case ({sv[i], rv[i]})
               2'b10:   n[i] = 1'b1;
               2'b01:   n[i] = 1'b0;
               2'b11:   n[i] = (p == 1) ? 1'b0 : (p == 2) ? 1'b1 : qc[i];
               default: n[i] = qc[i];
            endcase
         end
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic exp_t snapshot();
      exp_t x;
      for (int k = 0; k < 4; k++) begin
         x.q[k] = mq[k];
         x.e[k] = me[k];
      end
      return x;
   endfunction

   task automatic check_all(input string tag, input exp_t x);
      check({tag, " d0.q"},   {3'b0, q0},   {3'b0, x.q[0][0]});
      check({tag, " d0.qb"},  {3'b0, qb0},  {3'b0, ~x.q[0][0]});
      check({tag, " d0.err"}, {3'b0, err0}, {3'b0, x.e[0]});
      check({tag, " d1.q"},   {3'b0, q1},   {3'b0, x.q[1][0]});
      check({tag, " d1.qb"},  {3'b0, qb1},  {3'b0, ~x.q[1][0]});
      check({tag, " d1.err"}, {3'b0, err1}, {3'b0, x.e[1]});
      check({tag, " d2.q"},   {3'b0, q2},   {3'b0, x.q[2][0]});
      check({tag, " d2.qb"},  {3'b0, qb2},  {3'b0, ~x.q[2][0]});
      check({tag, " d2.err"}, {3'b0, err2}, {3'b0, x.e[2]});
      check({tag, " d4.q"},   q4,           x.q[3]);
      check({tag, " d4.qb"},  qb4,          ~x.q[3]);
      check({tag, " d4.err"}, {3'b0, err4}, {3'b0, x.e[3]});
   endtask

   // Drive one request, predict, let the DUT take the edge, then pop and compare
   task automatic step(input string tag, input logic e, input logic [3:0] sv, input logic [3:0] rv);
      logic [3:0] mask;
      en = e;
      s  = sv;
      r  = rv;
      for (int k = 0; k < 4; k++) begin
         mask  = (k == 3) ? 4'hF : 4'h1;
         mq[k] = model_next(mq[k], pol[k], e, sv & mask, rv & mask);
         me[k] = me[k] | (e & (|(sv & rv & mask)));
      end
      sb.push_back(snapshot());
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         check_all(tag, sb.pop_front());
      end
   endtask

   // Asynchronous reset pulse between edges, checked before any clock edge
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         mq[k] = 4'h0;
         me[k] = 1'b0;
      end
      sb.push_back(snapshot());
      check_all(tag, sb.pop_front());
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] v;
      logic       re;
      logic [3:0] rs, rr;

      for (int k = 0; k < 4; k++) begin
         mq[k] = 4'h0;
         me[k] = 1'b0;
      end

      #1;
      do_reset("t1_reset");

      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         step($sformatf("t2_v%0d", i), v[2], {4{v[1]}}, {4{v[0]}});
         if (i == 6) begin
            check("t2 set q0", {3'b0, q0}, 4'h1);
            check("t2 set qb0", {3'b0, qb0}, 4'h0);
         end
      end
      check("t2 hold q0", {3'b0, q0}, 4'h1);
      check("t2 err0", {3'b0, err0}, 4'h1);
      check("t3 rstdom q1", {3'b0, q1}, 4'h0);
      check("t3 err1", {3'b0, err1}, 4'h1);

      do_reset("t4_reset");
      step("t4_mixed", 1'b1, 4'b0101, 4'b0011);
      check("t4 q4", q4, 4'b0100);
      check("t4 err4", {3'b0, err4}, 4'h1);
      check("t3 setdom q2", {3'b0, q2}, 4'h1);

      step("t5_set", 1'b1, 4'hF, 4'h0);
      step("t5_conf", 1'b1, 4'h1, 4'h1);
      #3;
      do_reset("t5_async");
      rst = 1'b1;
      en  = 1'b1;
      s   = 4'hF;
      r   = 4'h0;
      @(posedge clk);
      #1;
      sb.push_back(snapshot());
      check_all("t5_override", sb.pop_front());
      rst = 1'b0;
      step("t5_release", 1'b1, 4'hF, 4'h0);
      check("t5 q4", q4, 4'hF);

      for (int i = 0; i < 1000; i++) begin
         re = ($urandom_range(0, 3) != 0);
         rs = 4'($urandom);
         rr = 4'($urandom);
         if (!re && $urandom_range(0, 1) == 1) begin
            rs = 4'bxz1x;
            rr = 4'bz1xx;
         end
         step("t6_rand", re, rs, rr);
         if (i % 250 == 249) do_reset("t6_reset");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
